// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if
//   Request / serial-output bundle of the serial pattern transmitter.
//   master : requester side  (drives start/pattern/count, observes x/valid/busy/done)
//   slave  : transmitter side (seq_pattern_tx)
//   Ports:
//     start   - transfer request, sampled only while the transmitter is idle
//     pattern - PAT_W-bit pattern, sent MSB first
//     count   - number of pattern repeats (0 = complete immediately)
//     x       - serial data bit
//     valid   - x carries a pattern bit
//     busy    - transfer in progress
//     done    - one-cycle completion pulse
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] count;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (output start, pattern, count, input x, valid, busy, done);
    modport slave  (input start, pattern, count, output x, valid, busy, done);
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial pattern transmitter. On an accepted start it shifts pattern out
//   MSB-first on x, repeats it count times, then pulses done for one cycle.
//   Optional macro SEQ_TX_GAP_EN: inserts GAP_LEN idle zero bits (valid=0)
//   between consecutive repeats; without it repeats are back-to-back and
//   GAP_LEN is ignored.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous active-high reset (wins over start, aborts silently)
//     bus - seq_pattern_tx_if.slave (start/pattern/count in, x/valid/busy/done out)
//   All outputs are registered: the output process decodes the *next* state
//   and the register process captures it, so outputs change on the same edge
//   as the state.
module seq_pattern_tx #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_tx_if.slave  bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_d, valid_d, busy_d, done_d;
`ifdef SEQ_TX_GAP_EN
    localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);
    logic [3:0]       gap_q, gap_d;
`endif

    // State and data registers, plus the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            bus.x     <= 1'b0;
            bus.valid <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
`ifdef SEQ_TX_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            bus.x     <= x_d;
            bus.valid <= valid_d;
            bus.busy  <= busy_d;
            bus.done  <= done_d;
`ifdef SEQ_TX_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
`ifdef SEQ_TX_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        state_d = SHIFT;
                        pat_d   = bus.pattern;
                        rem_d   = bus.count;
                        idx_d   = IDX_TOP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    // Bit 0 of this repeat is on x now; close the repeat.
                    rem_d = rem_q - 1'b1;
                    if (rem_q > CNT_W'(1)) begin
                        idx_d = IDX_TOP;
`ifdef SEQ_TX_GAP_EN
                        if (GAP_LEN > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LAST;
                        end
`endif
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
`ifdef SEQ_TX_GAP_EN
            GAP: begin
                // gap_q counts the gap cycles still to go after this one.
                if (gap_q == '0) state_d = SHIFT;
                else             gap_d   = gap_q - 1'b1;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state, registered above.
    always_comb begin
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            SHIFT: begin
                x_d     = pat_d[idx_d];
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
            GAP:     busy_d = 1'b1;
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 4;
    localparam int GAP_LEN = 2;
`ifdef SEQ_TX_GAP_EN
    localparam int GAPC = GAP_LEN;
`else
    localparam int GAPC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus();

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         nassert = 0;
    int         nfail   = 0;
    logic [3:0] exp_q[$];   // per-cycle {x, valid, busy, done}

    // Non-overlapping 1010 Mealy detector fed by x (loopback check).
    logic [1:0] dst;
    logic       z;
    int         zcnt = 0;
    assign z = (dst == 2'd3) && !bus.x;
    always_ff @(posedge clk) begin
        if (rst) dst <= 2'd0;
        else begin
            case (dst)
                2'd0: dst <= bus.x ? 2'd1 : 2'd0;
                2'd1: dst <= bus.x ? 2'd1 : 2'd2;
                2'd2: dst <= bus.x ? 2'd3 : 2'd0;
                default: dst <= bus.x ? 2'd1 : 2'd0;
            endcase
        end
    end
    always @(negedge clk) if (z) zcnt++;

    function automatic logic [3:0] obs();
        return {bus.x, bus.valid, bus.busy, bus.done};
    endfunction

    task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
        nassert++;
        assert (o === e)
        else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        nassert++;
        assert (o == e)
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expected output stream from the edge that accepts start onwards.
    task automatic push_xfer(input logic [3:0] pat, input int n);
        for (int r = 0; r < n; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
            if (r < n - 1)
                for (int g = 0; g < GAPC; g++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check(tag, obs(), 4'b0000);
        end
    endtask

    // restart_at / reset_at: entry index after which start is re-pulsed / rst asserted.
    task automatic xfer(input string tag, input logic [3:0] pat, input int n,
                        input int restart_at, input int reset_at);
        int         i;
        logic [3:0] e;
        i = 0;
        push_xfer(pat, n);
        bus.pattern = pat;
        bus.count   = CNT_W'(n);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.pattern = ~pat;     // post-acceptance changes must not matter
        bus.count   = 4'hF;
        while (exp_q.size() > 0) begin
            if (i > 0) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            e = exp_q.pop_front();
            check(tag, obs(), e);
            if (i == restart_at) begin
                bus.start   = 1'b1;
                bus.pattern = 4'b1111;
                bus.count   = 4'd5;
            end
            if (i == reset_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check({tag, "_rst"}, obs(), 4'b0000);
                exp_q.delete();
            end
            i++;
        end
    endtask

    initial begin
        int zbase;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.count   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), 4'b0000);
        rst = 1'b0;
        idle_check("idle", 2);

        xfer("p1010_n1", 4'b1010, 1, -1, -1);
        xfer("p1010_n3", 4'b1010, 3, -1, -1);
        xfer("p0111_n2", 4'b0111, 2, -1, -1);
        xfer("count0", 4'b1010, 0, -1, -1);
        xfer("ign_shift", 4'b1010, 2, 2, -1);
        xfer("ign_done", 4'b1010, 1, PAT_W, -1);
        idle_check("after_ign", 1);

        xfer("abort", 4'b1010, 2, -1, 2);
        idle_check("no_done", 3);
        xfer("fresh", 4'b0110, 2, -1, -1);

        // rst and start together: reset wins.
        rst         = 1'b1;
        bus.start   = 1'b1;
        bus.pattern = 4'b1010;
        bus.count   = 4'd3;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start", obs(), 4'b0000);
        idle_check("rst_start_idle", 3);

        zbase = zcnt;
        xfer("loop", 4'b1010, 2, -1, -1);
        idle_check("loop_idle", 2);
        check_int("loop_z", zcnt - zbase, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
